trivium_uniform_sampler: RTL and testbench

//   Consumer side of the Trivium64 keystream. Seeds and warms up one trivium64_update

---
 rtl/trivium_uniform_sampler_pkg.sv | 23 ++
 rtl/trivium_uniform_sampler_trivium64.sv | 43 ++++
 rtl/trivium_uniform_sampler.sv | 137 +++++++++++++
 tb/tb_trivium_uniform_sampler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/trivium_uniform_sampler_pkg.sv
// Shared definitions for the Trivium64 uniform coefficient sampler:
// buffer/word geometry, FSM state encoding and the seed-to-state mapping.
package trivium_uniform_sampler_pkg;

  localparam int BUF_W          = 128;
  localparam int WORD_W         = 64;
  localparam int TRIV_W         = 288;
  localparam int DEFAULT_WARMUP = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_WARMUP,
    ST_RUN,
    ST_DONE
  } state_t;

  // Seed fills the low key bits s1..s64; IV is all-zero; s286..s288 = 1.
  function automatic logic [TRIV_W-1:0] trivium_init(input logic [WORD_W-1:0] seed);
    return {3'b111, 221'b0, seed};
  endfunction

endpackage

// File: rtl/trivium_uniform_sampler_trivium64.sv
// Trivium core advancing 64 steps per enabled cycle; tout is the 64 keystream
// bits of the current state, bit i produced by step i.
module trivium64_update
  import trivium_uniform_sampler_pkg::*;
(
  input  logic              clk,
  input  logic              load_seed,
  input  logic              enable,
  input  logic [WORD_W-1:0] seed,
  output logic [WORD_W-1:0] tout
);

  logic [TRIV_W-1:0] st;
  logic [TRIV_W-1:0] st_next;

  always_comb begin
    logic t1, t2, t3;
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    t1      = 1'b0;
    t2      = 1'b0;
    t3      = 1'b0;
    st_next = st;
    tout    = '0;
    // NOTE: blocking assignments chain all 64 steps within one cycle.
    for (int i = 0; i < WORD_W; i++) begin
      t1      = st_next[65]  ^ st_next[92];
      t2      = st_next[161] ^ st_next[176];
      t3      = st_next[242] ^ st_next[287];
      tout[i] = t1 ^ t2 ^ t3;
      t1      = t1 ^ (st_next[90]  & st_next[91])  ^ st_next[170];
      t2      = t2 ^ (st_next[174] & st_next[175]) ^ st_next[263];
      t3      = t3 ^ (st_next[285] & st_next[286]) ^ st_next[68];
      st_next = {st_next[286:177], t2, st_next[175:93], t1, st_next[91:0], t3};
    end
  end

  // NOTE: the cipher state has no reset; every run reloads it through load_seed.
  always_ff @(posedge clk) begin
    if (load_seed)   st <= trivium_init(seed);
    else if (enable) st <= st_next;
  end

endmodule

// File: rtl/trivium_uniform_sampler.sv
// Seeds and warms up a Trivium64 core, slices its keystream into LOGQ-bit
// candidates, rejects those >= modulus and streams the rest out.
module trivium_uniform_sampler
  import trivium_uniform_sampler_pkg::*;
#(
  parameter int LOGQ   = 32,
  parameter int WARMUP = DEFAULT_WARMUP,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       seed,
  input  logic [LOGQ-1:0]   modulus,
  input  logic [CNT_W-1:0]  num_coeff,
  output logic [LOGQ-1:0]   coeff_data,
  output logic              coeff_valid,
  input  logic              coeff_ready,
  output logic              busy,
  output logic              done
);

  localparam int               WC_W   = $clog2(WARMUP + 1);
  localparam logic [7:0]       LOGQ_F = 8'(LOGQ);
  localparam logic [7:0]       WORD_F = 8'(WORD_W);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t            state;
  logic [63:0]       seed_q;
  logic [LOGQ-1:0]   mod_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  emitted;
  logic [WC_W-1:0]   warm_cnt;
  logic [7:0]        fill;
  logic [BUF_W-1:0]  bit_buf;

  logic              load_seed, enable, push, pop, accept, handshake, last;
  logic [WORD_W-1:0] tout;
  logic [LOGQ-1:0]   cand;
  logic [7:0]        post_fill, fill_next;
  logic [BUF_W-1:0]  buf_next;

  // issued counts accepted candidates (emitted + pending), so no pop overshoots num_q.
  assign pop       = (state == ST_RUN) && (fill >= LOGQ_F) &&
                     (!coeff_valid || coeff_ready) && (issued < num_q);
  assign push      = (state == ST_RUN) && (fill <= WORD_F);
  assign cand      = bit_buf[LOGQ-1:0];
  assign accept    = (mod_q == '0) || (cand < mod_q);
  assign handshake = coeff_valid && coeff_ready;
  assign last      = handshake && (emitted == num_q - ONE);
  assign load_seed = (state == ST_SEED);
  assign enable    = push || (state == ST_WARMUP);

  assign post_fill = pop ? fill - LOGQ_F : fill;
  assign fill_next = post_fill + (push ? WORD_F : 8'd0);
  assign buf_next  = (pop ? bit_buf >> LOGQ : bit_buf) |
                     (push ? {{(BUF_W-WORD_W){1'b0}}, tout} << post_fill : '0);

  trivium64_update u_trivium (
    .clk       (clk),
    .load_seed (load_seed),
    .enable    (enable),
    .seed      (seed_q),
    .tout      (tout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      seed_q      <= '0;
      mod_q       <= '0;
      num_q       <= '0;
      issued      <= '0;
      emitted     <= '0;
      warm_cnt    <= '0;
      fill        <= '0;
      bit_buf     <= '0;
      coeff_data  <= '0;
      coeff_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          seed_q  <= seed;
          mod_q   <= modulus;
          num_q   <= num_coeff;
          issued  <= '0;
          emitted <= '0;
          busy    <= 1'b1;
          if (num_coeff == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_SEED;
          end
        end
        ST_SEED: begin
          state    <= ST_WARMUP;
          warm_cnt <= '0;
          fill     <= '0;
          bit_buf  <= '0;
        end
        ST_WARMUP: begin
          warm_cnt <= warm_cnt + WC_W'(1);
          if (warm_cnt == WC_W'(WARMUP - 1)) state <= ST_RUN;
        end
        ST_RUN: begin
          bit_buf <= buf_next;
          fill    <= fill_next;
          if (pop && accept) begin
            coeff_data  <= cand;
            coeff_valid <= 1'b1;
            issued      <= issued + ONE;
          end else if (handshake) begin
            coeff_valid <= 1'b0;
          end
          if (handshake) emitted <= emitted + ONE;
          if (last) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            fill    <= '0;
            bit_buf <= '0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_uniform_sampler.sv
// Randomized bench for trivium_uniform_sampler against a bit-serial Trivium
// model that filters a flat keystream bit queue into expected coefficients.
module tb_trivium_uniform_sampler;

  localparam int LOGQ   = 32;
  localparam int WARMUP = 18;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [63:0]       seed;
  logic [LOGQ-1:0]   modulus;
  logic [CNT_W-1:0]  num_coeff;
  logic [LOGQ-1:0]   coeff_data;
  logic              coeff_valid;
  logic              coeff_ready;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;

  bit              ts [1:288];
  logic [LOGQ-1:0] exp_q [$];

  trivium_uniform_sampler #(.LOGQ(LOGQ), .WARMUP(WARMUP), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .modulus     (modulus),
    .num_coeff   (num_coeff),
    .coeff_data  (coeff_data),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.load_seed === 1'b1) load_cnt <= load_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Textbook Trivium, 1-based register indices, one keystream bit per call.
  task automatic tri_init(input logic [63:0] s);
    for (int i = 1; i <= 288; i++) ts[i] = 1'b0;
    for (int i = 1; i <= 64; i++)  ts[i] = s[i-1];
    ts[286] = 1'b1; ts[287] = 1'b1; ts[288] = 1'b1;
  endtask

  task automatic tri_step(output bit z);
    bit t1, t2, t3;
    t1 = ts[66] ^ ts[93];
    t2 = ts[162] ^ ts[177];
    t3 = ts[243] ^ ts[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ts[91] & ts[92]) ^ ts[171];
    t2 = t2 ^ (ts[175] & ts[176]) ^ ts[264];
    t3 = t3 ^ (ts[286] & ts[287]) ^ ts[69];
    for (int i = 288; i >= 179; i--) ts[i] = ts[i-1];
    ts[178] = t2;
    for (int i = 177; i >= 95; i--) ts[i] = ts[i-1];
    ts[94] = t1;
    for (int i = 93; i >= 2; i--) ts[i] = ts[i-1];
    ts[1] = t3;
  endtask

  task automatic gen_expected(input logic [63:0] s, input logic [LOGQ-1:0] m, input int n);
    bit z;
    logic [LOGQ-1:0] c;
    exp_q.delete();
    tri_init(s);
    for (int i = 0; i < WARMUP * 64; i++) tri_step(z);
    while (exp_q.size() < n) begin
      c = '0;
      for (int b = 0; b < LOGQ; b++) begin
        tri_step(z);
        c[b] = z;
      end
      if (m == '0 || c < m) exp_q.push_back(c);
    end
  endtask

  // Starts a run and consumes it; mode 0 ready=1, 1 random, 2 stalled 50 cycles at stall_at.
  task automatic run(input string tag, input logic [63:0] s, input logic [LOGQ-1:0] m,
                     input int n, input int mode, input int stall_at, input bit poke,
                     output int first_lat);
    int k, got;
    bit pv, pr, fin;
    logic [LOGQ-1:0] pd;
    gen_expected(s, m, n);
    seed = s; modulus = m; num_coeff = CNT_W'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; got = 0; pv = 0; pr = 0; pd = '0; fin = 0; first_lat = -1;
    while (!fin) begin
      if (coeff_valid && first_lat < 0) first_lat = k;
      if (pv && !pr) begin
        check({tag, "_hold_valid"}, coeff_valid, 1);
        check({tag, "_hold_data"}, coeff_data, pd);
      end
      case (mode)
        0:       coeff_ready = 1'b1;
        1:       coeff_ready = 1'($urandom_range(0, 1));
        default: coeff_ready = !(k >= stall_at && k < stall_at + 50);
      endcase
      if (mode == 2 && k == stall_at + 49) check({tag, "_stall_enable"}, dut.enable, 0);
      if (poke) begin
        if (k == 5 || k == 22) begin
          start = 1'b1; seed = ~s; modulus = $urandom; num_coeff = CNT_W'($urandom);
        end else begin
          start = 1'b0; seed = s; modulus = m; num_coeff = CNT_W'(n);
        end
      end
      if (coeff_valid && coeff_ready) begin
        if (got < exp_q.size()) check({tag, "_data"}, coeff_data, exp_q[got]);
        if (m != '0) check({tag, "_bound"}, coeff_data < m, 1);
        got++;
      end
      pv = coeff_valid; pr = coeff_ready; pd = coeff_data;
      @(posedge clk); #1;
      k++;
      if (got == n && pv && pr) begin
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 1);
        @(posedge clk); #1;
        check({tag, "_done_clear"}, done, 0);
        check({tag, "_busy_clear"}, busy, 0);
        check({tag, "_valid_clear"}, coeff_valid, 0);
        fin = 1;
      end else if (done) begin
        check({tag, "_early_done"}, got, n);
        fin = 1;
      end else if (k > 5000) begin
        check({tag, "_timeout"}, got, n);
        fin = 1;
      end
    end
    start = 1'b0; seed = s; modulus = m;
  endtask

  initial begin
    int lat, snap;
    rst = 1'b1; start = 1'b0; seed = '0; modulus = '0; num_coeff = '0; coeff_ready = 1'b1;
    #1;
    check("rst_valid", coeff_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", coeff_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run("t1", 64'h0123456789ABCDEF, '0, 4, 0, 0, 1'b0, lat);
    check("t1_latency", lat, 21);

    run("t2", {$urandom, $urandom}, 32'h8000_0000, 64, 1, 0, 1'b0, lat);

    run("t3", {$urandom, $urandom}, 32'hC000_0000 | LOGQ'($urandom), 40, 2, 30, 1'b0, lat);

    snap = load_cnt;
    seed = {$urandom, $urandom}; num_coeff = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_done", done, 1);
    check("t4_valid", coeff_valid, 0);
    @(posedge clk); #1;
    check("t4_done_clear", done, 0);
    check("t4_busy", busy, 0);
    check("t4_valid_after", coeff_valid, 0);
    check("t4_load_seed", load_cnt, snap);

    run("t5", 64'h0123456789ABCDEF, '0, 4, 0, 0, 1'b1, lat);
    check("t5_latency", lat, 21);

    coeff_ready = 1'b0;
    seed = 64'h0123456789ABCDEF; modulus = '0; num_coeff = CNT_W'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (24) begin @(posedge clk); #1; end
    check("t6_pre_valid", coeff_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", coeff_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    run("t6", 64'h0123456789ABCDEF, '0, 4, 0, 0, 1'b0, lat);
    check("t6_latency", lat, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
